// File: rtl/lc3_pkg.sv
//==============================================================================
// lc3_pkg: device address map and controller state encoding for the LC-3
// memory/IO controller.  Rev 1.0
//==============================================================================
`default_nettype none

package lc3_pkg;

    localparam logic [15:0] DEV_BASE  = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic is_dev(input logic [15:0] addr);
        return addr >= DEV_BASE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_dev_regs.sv
//==============================================================================
// lc3_dev_regs: memory-mapped KBSR/KBDR/DSR/DDR/MCR with keyboard and display
// handshakes.  Rev 1.0
//==============================================================================
`default_nettype none

module lc3_dev_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        acc,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata_lo,
    input  logic        wdata_msb,
    output logic [15:0] rd_val,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        run
);

    logic       kbsr15;
    logic [7:0] kbdr;
    logic       dsr15;
    logic       mcr15;
    logic       kbdr_rd;
    logic       ddr_wr;
    logic       mcr_wr;

    // acc is asserted only on the edge the controller leaves IDLE for DONE
    assign kbdr_rd  = acc && !we && (addr == KBDR_ADDR);
    assign ddr_wr   = acc &&  we && (addr == DDR_ADDR);
    assign mcr_wr   = acc &&  we && (addr == MCR_ADDR);
    assign kb_ready = ~kbsr15;
    assign run      = mcr15;

    always_comb begin
        rd_val = 16'h0000;
        case (addr)
            KBSR_ADDR: rd_val = {kbsr15, 15'b0};
            KBDR_ADDR: rd_val = {8'h00, kbdr};
            DSR_ADDR:  rd_val = {dsr15, 15'b0};
            MCR_ADDR:  rd_val = {mcr15, 15'b0};
            default:   rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kbsr15     <= 1'b0;
            kbdr       <= 8'h00;
            dsr15      <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
            mcr15      <= 1'b1;
        end else begin
            // a KBDR read beats a simultaneous keystroke, which stays pending
            if (kbdr_rd) begin
                kbsr15 <= 1'b0;
            end else if (kb_valid && !kbsr15) begin
                kbdr   <= kb_data;
                kbsr15 <= 1'b1;
            end

            if (ddr_wr) begin
                disp_data  <= wdata_lo;
                disp_valid <= 1'b1;
                dsr15      <= 1'b0;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
                dsr15      <= 1'b1;
            end

            if (mcr_wr) begin
                mcr15 <= wdata_msb;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
//==============================================================================
// lc3_mem_ctrl: LC-3 memory/IO access controller; fixed-wait SRAM cycles below
// DEV_BASE, single-cycle device register accesses above it.  Rev 1.0
//==============================================================================
`default_nettype none

module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        run
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        dev_acc;
    logic [15:0] dev_rd;

    assign dev_acc    = (state == ST_IDLE) && mio_en && is_dev(mar);
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    lc3_dev_regs u_dev_regs (
        .clk        (clk),
        .rst        (rst),
        .acc        (dev_acc),
        .we         (r_w),
        .addr       (mar),
        .wdata_lo   (mdr_in[7:0]),
        .wdata_msb  (mdr_in[15]),
        .rd_val     (dev_rd),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .run        (run)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            ready   <= 1'b0;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            rdata   <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b0;
                    if (mio_en) begin
                        addr_q  <= mar;
                        we_q    <= r_w;
                        wdata_q <= mdr_in;
                        if (is_dev(mar)) begin
                            state <= ST_DONE;
                            ready <= 1'b1;
                            if (!r_w) begin
                                rdata <= dev_rd;
                            end
                        end else begin
                            state   <= ST_ACCESS;
                            cnt     <= WAIT_LAST;
                            sram_en <= 1'b1;
                            sram_we <= r_w;
                        end
                    end
                end
                ST_ACCESS: begin
                    // sram_rdata is only guaranteed in the final strobe cycle
                    if (cnt == 4'd0) begin
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                        ready   <= 1'b1;
                        state   <= ST_DONE;
                        if (!we_q) begin
                            rdata <= sram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready   <= 1'b0;
                    sram_en <= 1'b0;
                    sram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 Parameter: MEM_WAIT, default 2, number of cycles sram_en/sram_addr are held per memory access (legal range 1..15).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 mio_en  input  1  memory/IO access request from the datapath control bits.
REQ-005 r_w  input  1  1 = write, 0 = read; sampled with mio_en.
REQ-006 mar  input  16  access address.
REQ-007 mdr_in  input  16  write data.
REQ-008 ready  output  1  access complete; feeds the microsequencer R condition.
REQ-009 rdata  output  16  read data to the MDR; valid while ready=1.
REQ-010 sram_en, sram_we  output  1 each  external synchronous SRAM strobe and write enable.
REQ-011 sram_addr, sram_wdata  output  16 each  SRAM address and write data.
REQ-012 sram_rdata  input  16  SRAM read data; valid in the last cycle of sram_en.
REQ-013 kb_valid, kb_data[7:0] input; kb_ready output  keyboard source handshake.
REQ-014 disp_valid, disp_data[7:0] output; disp_ready input  display sink handshake.
REQ-015 run  output  1  MCR[15]; the clock-enable for the processor.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE: on mio_en=1, latch mar, r_w and mdr_in; go to DONE if mar>=16'hFE00 (device space), else go to ACCESS.
REQ-018 ACCESS: sram_en=1 and sram_we=latched r_w for exactly MEM_WAIT cycles (counter); on the last cycle, capture sram_rdata into rdata on reads, then go to DONE.
REQ-019 DONE: ready=1 for exactly one cycle, then IDLE unconditionally; mio_en is ignored in DONE, and a request still asserted is accepted again in the following IDLE cycle.
REQ-020 Latency, request sampled in IDLE at edge N: memory ready=1 in cycle N+1+MEM_WAIT; device ready=1 in cycle N+1.
REQ-021 ready, sram_en and sram_we are driven only from state and registers; no combinational path from any input to these outputs.
REQ-022 Device map: KBSR FE00, KBDR FE02, DSR FE04, DDR FE06, MCR FFFE.
REQ-023 Any other address >= FE00 reads 0, ignores writes and completes with device latency.
REQ-024 Register read values:
- KBSR reads {kbsr15,15'b0}.
- KBDR reads {8'b0,kbdr}.
- DSR reads {dsr15,15'b0}.
- MCR reads {mcr15,15'b0}.
REQ-025 Device reads load rdata on entry to DONE.
REQ-026 Writes to KBSR, KBDR and DSR are ignored.
REQ-027 kb_ready = ~kbsr15. When kb_valid & kb_ready: kbdr<=kb_data, kbsr15<=1.
REQ-028 A read of KBDR clears kbsr15 on entry to DONE.
REQ-029 If a KBDR read and kb_valid occur in the same cycle, the clear wins and kb_data is not accepted in that cycle.
REQ-030 A DDR write loads disp_data<=mdr_in[7:0], sets disp_valid=1 and clears dsr15.
REQ-031 When disp_valid & disp_ready: disp_valid<=0 and dsr15<=1.
REQ-032 A DDR write coinciding with disp_ready: the write wins, the new character is presented, and dsr15 stays 0.
REQ-033 A write to MCR sets mcr15<=mdr_in[15]; run=mcr15.
REQ-034 Address wrap: memory addresses 0000..FDFF only; no wrap or carry is performed on mar.

Reset
REQ-035 On rst=0 the block shall immediately return to IDLE, including mid-access (any abandoned SRAM write may be partial).
REQ-036 Reset values:
- ready=0, sram_en=0, sram_we=0.
- rdata=0.
- kbsr15=0, kbdr=0.
- dsr15=1, disp_valid=0.
- mcr15=1, so run=1.

Structure
REQ-037 A shared package lc3_pkg shall hold:
- the device address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR, DEV_BASE=16'hFE00);
- the FSM state encoding.
REQ-038 One sub-module, lc3_dev_regs, shall contain KBSR/KBDR/DSR/DDR/MCR and their handshakes; lc3_mem_ctrl holds the FSM, the wait counter and the SRAM interface.

Verification
REQ-039 Memory read, MEM_WAIT=2, sram_rdata=16'h1234: mio_en=1,r_w=0,mar=3000 at edge N -> sram_en high cycles N+1..N+2, ready=1 only in N+3 with rdata=1234.
REQ-040 Memory write, mar=3001, mdr_in=ABCD -> sram_we=1, sram_addr=3001, sram_wdata=ABCD for 2 cycles; single ready pulse.
REQ-041 Keyboard: kb_valid=1, kb_data=41 -> KBSR read returns 8000; KBDR read returns 0041; subsequent KBSR read returns 0000; kb_ready returns to 1.
REQ-042 Display: write DDR=0048 with disp_ready=0 -> disp_valid=1, DSR reads 0000; raise disp_ready -> disp_valid=0, DSR reads 8000.
REQ-043 MCR write 0000 -> run=0; then rst pulsed during an ACCESS cycle -> ready=0, sram_en=0, run=1 immediately.
REQ-044 Back-to-back: mio_en held high across two reads -> two distinct ready pulses separated by at least one IDLE cycle.
